// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, timer source index
// and MMIO register offsets for the mask and pending registers.
package irq_controller_pkg;

  localparam int IRQ_NSRC  = 4;
  localparam int IRQ_TIMER = 0;

  localparam logic [7:0] IRQ_MASK_OFS    = 8'h00;
  localparam logic [7:0] IRQ_PENDING_OFS = 8'h04;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SERV = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int IDW  = 4
) (
  input  logic [NSRC-1:0] vec,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    valid = |vec;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// CPU-side interrupt controller: edge capture into pending, per-source mask,
// lowest-index priority and a request/ack/eoi handshake with the CPU.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NSRC = IRQ_NSRC,
  parameter int IDW  = 4
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NSRC-1:0] irq_src,
  input  logic            global_int_en,
  output logic            irq_to_cpu,
  output logic [IDW-1:0]  int_id,
  input  logic            int_ack,
  input  logic            eoi,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask_q,
  output logic [NSRC-1:0] pending_q,
  output logic            in_service,
  output irq_state_t      state
);

  // Handshake: irq_to_cpu is a request qualified by global_int_en while in REQ.
  // An int_ack is accepted only on a cycle where irq_to_cpu is high and int_id
  // is still eligible; acceptance moves to SERV, which lasts until a single eoi.
  // Pulses of int_ack or eoi in any other state are dropped.

  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] id_onehot;
  logic [NSRC-1:0] ack_clr;
  logic            enc_valid;
  logic [IDW-1:0]  enc_idx;
  logic            id_ok;
  logic            ack_take;

  // Input stage plus history register gives the 3-cycle rise-to-request latency.
  assign rise      = src_s & ~src_d;
  assign eligible  = pending_q & mask_q;
  assign id_onehot = NSRC'(1) << int_id;
  assign id_ok     = |(eligible & id_onehot);
  assign ack_take  = (state == IRQ_REQ) && id_ok && int_ack && global_int_en;
  assign ack_clr   = ack_take ? id_onehot : '0;

  assign irq_to_cpu = (state == IRQ_REQ) && global_int_en;
  assign in_service = (state == IRQ_SERV);

  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .vec   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      src_s <= '0;
      src_d <= '0;
    end else begin
      src_s <= irq_src;
      src_d <= src_s;
    end
  end

  // A new edge on the same cycle as its ack clear leaves the bit set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_clr) | rise;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IRQ_IDLE;
      int_id <= '0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (enc_valid) begin
            state  <= IRQ_REQ;
            int_id <= enc_idx;
          end
        end
        IRQ_REQ: begin
          if (!id_ok)        state <= IRQ_IDLE;
          else if (ack_take) state <= IRQ_SERV;
        end
        IRQ_SERV: begin
          if (eoi) state <= IRQ_IDLE;
        end
        default: state <= IRQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-computed expectations for latency,
// priority, IE gating, mask withdrawal, set-over-clear and async reset.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam int NSRC = 4;
  localparam int IDW  = 4;

  logic            clk;
  logic            clrn;
  logic [NSRC-1:0] irq_src;
  logic            global_int_en;
  logic            irq_to_cpu;
  logic [IDW-1:0]  int_id;
  logic            int_ack;
  logic            eoi;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pending_q;
  logic            in_service;
  irq_state_t      state;

  int checks = 0;
  int errors = 0;
  logic [IDW-1:0] exp_q[$];

  irq_controller #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .irq_src       (irq_src),
    .global_int_en (global_int_en),
    .irq_to_cpu    (irq_to_cpu),
    .int_id        (int_id),
    .int_ack       (int_ack),
    .eoi           (eoi),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .mask_q        (mask_q),
    .pending_q     (pending_q),
    .in_service    (in_service),
    .state         (state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: step one clock, sample #1 after the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [NSRC-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    step();
    mask_we    = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  initial begin
    clrn          = 1'b0;
    irq_src       = '0;
    global_int_en = 1'b0;
    int_ack       = 1'b0;
    eoi           = 1'b0;
    mask_we       = 1'b0;
    mask_wdata    = '0;
    step(2);
    check("reset_state", 32'(state), 32'(IRQ_IDLE));
    check("reset_irq", 32'(irq_to_cpu), 0);
    check("reset_mask", 32'(mask_q), 0);
    clrn = 1'b1;
    step();

    // stray ack/eoi in IDLE are ignored
    pulse_ack();
    pulse_eoi();
    check("stray_state", 32'(state), 32'(IRQ_IDLE));
    check("stray_svc", 32'(in_service), 0);

    // single timer pulse, 3-cycle latency
    write_mask(4'b0001);
    check("t2_mask", 32'(mask_q), 32'h1);
    global_int_en = 1'b1;
    irq_src = 4'b0001;
    step(2);
    check("t2_irq_early", 32'(irq_to_cpu), 0);
    step();
    check("t2_irq_lat3", 32'(irq_to_cpu), 1);
    check("t2_id", 32'(int_id), 0);
    pulse_ack();
    check("t2_irq_ack", 32'(irq_to_cpu), 0);
    check("t2_svc", 32'(in_service), 1);
    check("t2_pend", 32'(pending_q), 0);
    step(4);
    irq_src = 4'b0000;
    pulse_eoi();
    check("t2_svc_eoi", 32'(in_service), 0);
    step(4);
    check("t2_no_rereq", 32'(irq_to_cpu), 0);
    check("t2_idle", 32'(state), 32'(IRQ_IDLE));

    // priority: src 1 before src 2
    write_mask(4'b1111);
    exp_q.push_back(IDW'(1));
    exp_q.push_back(IDW'(2));
    irq_src = 4'b0110;
    step(3);
    check("t3_pend", 32'(pending_q), 32'h6);
    check("t3_req", 32'(irq_to_cpu), 1);
    check("t3_id_first", 32'(int_id), 32'(exp_q.pop_front()));
    pulse_ack();
    check("t3_pend_ack", 32'(pending_q), 32'h4);
    pulse_eoi();
    check("t3_gap_idle", 32'(state), 32'(IRQ_IDLE));
    check("t3_gap_irq", 32'(irq_to_cpu), 0);
    step();
    check("t3_req2", 32'(state), 32'(IRQ_REQ));
    check("t3_id_second", 32'(int_id), 32'(exp_q.pop_front()));
    pulse_ack();
    pulse_eoi();
    irq_src = 4'b0000;
    step();
    check("t3_q_empty", 32'(exp_q.size()), 0);
    check("t3_pend_end", 32'(pending_q), 0);

    // IE gating: request held back, ack ignored
    global_int_en = 1'b0;
    irq_src = 4'b0001;
    step(3);
    check("t4_state", 32'(state), 32'(IRQ_REQ));
    check("t4_irq_ie0", 32'(irq_to_cpu), 0);
    pulse_ack();
    check("t4_ack_ign", 32'(state), 32'(IRQ_REQ));
    check("t4_pend", 32'(pending_q), 32'h1);
    global_int_en = 1'b1;
    #1;
    check("t4_irq_ie1", 32'(irq_to_cpu), 1);
    pulse_ack();
    check("t4_serv", 32'(state), 32'(IRQ_SERV));
    pulse_eoi();
    irq_src = 4'b0000;
    step();

    // mask write withdraws request
    irq_src = 4'b0010;
    step(3);
    check("t5_id", 32'(int_id), 1);
    write_mask(4'b1101);
    check("t5_mask", 32'(mask_q), 32'hd);
    step();
    check("t5_state", 32'(state), 32'(IRQ_IDLE));
    check("t5_irq", 32'(irq_to_cpu), 0);
    check("t5_pend", 32'(pending_q), 32'h2);
    step(2);
    check("t5_stay", 32'(state), 32'(IRQ_IDLE));

    // new edge on src 0 lands on its own ack edge
    write_mask(4'b0001);
    irq_src = 4'b0001;
    step(3);
    check("t6_req", 32'(state), 32'(IRQ_REQ));
    irq_src = 4'b0000;
    step();
    irq_src = 4'b0001;
    step();
    pulse_ack();
    check("t6_serv", 32'(state), 32'(IRQ_SERV));
    check("t6_pend_set", 32'(pending_q), 32'h3);
    pulse_eoi();
    check("t6_idle", 32'(state), 32'(IRQ_IDLE));
    step();
    check("t6_rereq", 32'(state), 32'(IRQ_REQ));
    check("t6_id", 32'(int_id), 0);

    // async reset mid-SERV
    pulse_ack();
    check("t1_serv", 32'(in_service), 1);
    clrn = 1'b0;
    #1;
    check("t1_state", 32'(state), 32'(IRQ_IDLE));
    check("t1_svc", 32'(in_service), 0);
    check("t1_irq", 32'(irq_to_cpu), 0);
    check("t1_pend", 32'(pending_q), 0);
    check("t1_mask", 32'(mask_q), 0);
    check("t1_id", 32'(int_id), 0);
    step();
    clrn = 1'b1;
    step(3);
    check("t1_after", 32'(state), 32'(IRQ_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
